// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the baud
// divider calculation used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clocks per oversampling tick; integer truncation, so the line rate is
  // slightly fast when CLK_FREQ is not an exact multiple.
  function automatic int calc_tick_div(input int clk_freq, input int baud_rate,
                                       input int oversampling);
    return clk_freq / (baud_rate * oversampling);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: the serial line plus the byte/valid/error/busy
// outputs of the receiver.
interface uart_rx_if;
  import uart_pkg::*;

  // Handshake: rx_valid and rx_error are single-cycle pulses with no ready;
  // rx_data is stable from the rx_valid cycle until the next rx_valid, and a
  // byte the consumer misses is simply overwritten.
  logic                 rx_serial;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_error;
  logic                 rx_busy;

  modport master (
    output rx_serial,
    input  rx_data,
    input  rx_valid,
    input  rx_error,
    input  rx_busy
  );

  modport slave (
    input  rx_serial,
    output rx_data,
    output rx_valid,
    output rx_error,
    output rx_busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: registered one-cycle tick every TICK_DIV clocks
// while enabled; dropping the enable clears the phase.
module uart_baud_tick #(
  parameter int TICK_DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: TICK_DIV must be at least 1");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, detects the start edge, samples
// mid-bit using an oversampled tick and reports good bytes or framing errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int OVERSAMPLING = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_serial,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_rx_error,
  output logic                 o_rx_busy,
  output rx_state_t            dbg_state
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLING);
  localparam int TW       = $clog2(OVERSAMPLING);
  localparam int BW       = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLING / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  if (OVERSAMPLING < 4 || (OVERSAMPLING % 2) != 0) begin : g_bad_os
    $error("uart_rx: OVERSAMPLING must be even and at least 4");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("uart_rx: CLK_FREQ too low for BAUD_RATE*OVERSAMPLING");
  end

  logic       sync1, sync2, sync3;
  logic [2:0] primed;
  logic       fall;
  logic       tick;

  // The synchroniser presets to 1 on reset; primed keeps that artificial 1
  // from looking like a start edge when the line is low at reset release.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync3  <= 1'b1;
      primed <= '0;
    end else begin
      sync1  <= i_rx_serial;
      sync2  <= sync1;
      sync3  <= sync2;
      primed <= {primed[1:0], 1'b1};
    end
  end

  assign fall = primed[2] & sync3 & ~sync2;

  rx_state_t            state, state_nxt;
  logic [TW-1:0]        tcnt, tcnt_nxt;
  logic [BW-1:0]        bit_idx, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt, error_nxt;

  uart_baud_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (i_clk),
    .rst  (i_reset),
    .en   ((state != IDLE) || fall),
    .tick (tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      tcnt       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_rx_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      tcnt       <= tcnt_nxt;
      bit_idx    <= bit_nxt;
      shift      <= shift_nxt;
      o_rx_data  <= data_nxt;
      o_rx_valid <= valid_nxt;
      o_rx_error <= error_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    data_nxt  = o_rx_data;
    valid_nxt = 1'b0;
    error_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        tcnt_nxt = '0;
        bit_nxt  = '0;
        if (fall) state_nxt = START;
      end
      START: begin
        // Half a bit in: a line back high means the edge was a glitch.
        if (tick) begin
          if (tcnt == HALF_LAST) begin
            tcnt_nxt  = '0;
            state_nxt = sync2 ? IDLE : DATA;
          end else begin
            tcnt_nxt = tcnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tcnt == FULL_LAST) begin
            tcnt_nxt  = '0;
            shift_nxt = {sync2, shift[DATA_BITS-1:1]};
            bit_nxt   = bit_idx + BW'(1);
            if (bit_idx == LAST_BIT) state_nxt = STOP;
          end else begin
            tcnt_nxt = tcnt + TW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tcnt == FULL_LAST) begin
            tcnt_nxt  = '0;
            state_nxt = IDLE;
            if (sync2) begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
            end else begin
              error_nxt = 1'b1;
            end
          end else begin
            tcnt_nxt = tcnt + TW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_rx_busy = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives 8N1 frames on the serial line and checks received
// bytes, framing errors, pulse timing, glitch rejection and reset behaviour.
module tb_uart_rx;
  import uart_pkg::*;

  // Scaled clock so that TICK_DIV = 4 and a bit lasts 64 clocks.
  localparam int CLK_FREQ     = 7372800;
  localparam int BAUD_RATE    = 115200;
  localparam int OVERSAMPLING = 16;
  localparam int TICK_DIV     = CLK_FREQ / (BAUD_RATE * OVERSAMPLING);
  localparam int BIT_CYC      = TICK_DIV * OVERSAMPLING;
  // Pin falls in cycle P, E = P + 2, pulse at E + (OS/2 + 9*OS)*TICK_DIV + 1.
  localparam int PULSE_OFS    = 2 + (OVERSAMPLING / 2 + 9 * OVERSAMPLING) * TICK_DIV + 1;

  logic      clk;
  logic      rst;
  rx_state_t dbg;
  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD_RATE    (BAUD_RATE),
    .OVERSAMPLING (OVERSAMPLING)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_rx_serial (bus.rx_serial),
    .o_rx_data   (bus.rx_data),
    .o_rx_valid  (bus.rx_valid),
    .o_rx_error  (bus.rx_error),
    .o_rx_busy   (bus.rx_busy),
    .dbg_state   (dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Scoreboard entries: {is_error, data expected on rx_data at the pulse}
  logic [8:0] exp_q[$];
  logic [7:0] model_data;
  int         t_pin;
  int         last_pulse = -1;
  int         busy_rise  = -1;
  int         busy_fall  = -1;
  logic       busy_prev  = 1'b0;

  // Monitor: every valid/error pulse pops one expected event
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (bus.rx_busy && !busy_prev) busy_rise = cyc;
      if (!bus.rx_busy && busy_prev) busy_fall = cyc;
    end
    busy_prev = bus.rx_busy;
    if (bus.rx_valid || bus.rx_error) begin
      checks++;
      last_pulse = cyc;
      if (bus.rx_valid && bus.rx_error) begin
        errors++;
        $display("FAIL both_pulses cycle=%0d valid=1 error=1 required at most one", cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cycle=%0d valid=%0b error=%0b data=%02h",
                 cyc, bus.rx_valid, bus.rx_error, bus.rx_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.rx_error, bus.rx_data} !== e) begin
          errors++;
          $display("FAIL rx_event cycle=%0d got err=%0b data=%02h required err=%0b data=%02h",
                   cyc, bus.rx_error, bus.rx_data, e[8], e[7:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int period);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    if (stop) begin
      exp_q.push_back({1'b0, b});
      model_data = b;
    end else begin
      exp_q.push_back({1'b1, model_data});
    end
    for (int i = 0; i < 10; i++) begin
      bus.rx_serial = bits[i];
      if (i == 0) t_pin = cyc;
      idle(period);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    bus.rx_serial = 1'b1;
    model_data = 8'h00;
    idle(5);
    rst = 1'b0;
    checks += 5;
    if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h required 00", bus.rx_data); end
    if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b required 0", bus.rx_valid); end
    if (bus.rx_error !== 1'b0) begin errors++; $display("FAIL reset_error got %0b required 0", bus.rx_error); end
    if (bus.rx_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %0b required 0", bus.rx_busy); end
    if (dbg !== IDLE)          begin errors++; $display("FAIL reset_state got %0d required IDLE", dbg); end
    idle(10);
  endtask

  task automatic test_single_frame();
    int t0;
    send_frame(8'hA5, 1'b1, BIT_CYC);
    t0 = t_pin;
    idle(BIT_CYC);
    check_drained("single_drain");
    checks += 4;
    if (last_pulse !== t0 + PULSE_OFS) begin
      errors++; $display("FAIL single_pulse_cycle got %0d required %0d", last_pulse, t0 + PULSE_OFS);
    end
    if (busy_rise !== t0 + 3) begin
      errors++; $display("FAIL single_busy_rise got %0d required %0d", busy_rise, t0 + 3);
    end
    if (busy_fall !== t0 + PULSE_OFS) begin
      errors++; $display("FAIL single_busy_fall got %0d required %0d", busy_fall, t0 + PULSE_OFS);
    end
    if (bus.rx_data !== 8'hA5) begin
      errors++; $display("FAIL single_data_hold got %02h required a5", bus.rx_data);
    end
  endtask

  task automatic test_glitch();
    bus.rx_serial = 1'b0;
    idle(10);
    checks++;
    if (bus.rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_detect busy=%0b required 1", bus.rx_busy); end
    idle(10);
    bus.rx_serial = 1'b1;
    idle(100);
    checks += 2;
    if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %0b required 0", bus.rx_busy); end
    if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL glitch_data got %02h required a5", bus.rx_data); end
    send_frame(8'h3C, 1'b1, BIT_CYC);
    idle(BIT_CYC);
    check_drained("glitch_next_frame");
  endtask

  task automatic test_framing_error();
    send_frame(8'h5A, 1'b0, BIT_CYC);
    idle(2 * BIT_CYC);
    checks += 2;
    if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL break_retrigger busy=%0b required 0", bus.rx_busy); end
    if (bus.rx_data !== 8'h3C) begin errors++; $display("FAIL error_data_hold got %02h required 3c", bus.rx_data); end
    idle(3 * BIT_CYC);
    check_drained("framing_error_pulse");
    bus.rx_serial = 1'b1;
    idle(BIT_CYC);
    send_frame(8'h81, 1'b1, BIT_CYC);
    idle(BIT_CYC);
    check_drained("after_break_frame");
  endtask

  task automatic test_back_to_back();
    int periods[2] = '{BIT_CYC, BIT_CYC - 1};
    foreach (periods[p]) begin
      send_frame(8'h00, 1'b1, periods[p]);
      send_frame(8'hFF, 1'b1, periods[p]);
      send_frame(8'h55, 1'b1, periods[p]);
      idle(2 * BIT_CYC);
      check_drained("back_to_back");
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] bits;
    bits = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx_serial = bits[i];
      if (i == 4) begin
        idle(30);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        model_data = 8'h00;
        checks += 4;
        if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL midreset_data got %02h required 00", bus.rx_data); end
        if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %0b required 0", bus.rx_valid); end
        if (bus.rx_error !== 1'b0) begin errors++; $display("FAIL midreset_error got %0b required 0", bus.rx_error); end
        if (bus.rx_busy !== 1'b0)  begin errors++; $display("FAIL midreset_busy got %0b required 0", bus.rx_busy); end
        idle(BIT_CYC - 31);
      end else begin
        idle(BIT_CYC);
      end
    end
    idle(3 * BIT_CYC);
    checks++;
    if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL midreset_phantom busy=%0b required 0", bus.rx_busy); end
    send_frame(8'h96, 1'b1, BIT_CYC);
    idle(BIT_CYC);
    check_drained("midreset_next_frame");
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 24; i++) begin
      idle($urandom_range(0, 40));
      send_frame(8'($urandom_range(0, 255)), 1'b1, BIT_CYC);
    end
    idle(BIT_CYC);
    check_drained("random_stream");
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_serial = 1'b1;
    test_reset();
    test_single_frame();
    test_glitch();
    test_framing_error();
    test_back_to_back();
    test_reset_midframe();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout cycle=%0d required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link: deserialises 8N1 frames from an asynchronous RX pin into bytes using an oversampled baud tick. It is the receive counterpart of `UART_TX` and shares its parameter set, so a TX/RX pair built with identical parameters interoperates. Bytes are delivered as a one-cycle valid pulse with held data. Framing errors are flagged separately.

## Interface
- `CLK_FREQ`, 100000000, system clock frequency in Hz.
- `BAUD_RATE`, 115200, line rate in bit/s.
- `OVERSAMPLING`, 16, ticks per bit.
  - Must be even and ≥ 4; an elaboration-time assertion enforces this.
- `i_clk`  in  1  system clock; single clock domain.
- `i_reset`  in  1  reset; synchronous, active-high.
- `i_rx_serial`  in  1  asynchronous RX line; idles high.
- `o_rx_data`  out  8  last correctly framed byte; held until the next good frame.
- `o_rx_valid`  out  1  one-cycle pulse when `o_rx_data` updates.
- `o_rx_error`  out  1  one-cycle pulse on a framing error (stop bit sampled 0).
- `o_rx_busy`  out  1  high while in any state other than IDLE.

## Operation
- **Input synchronisation:** `i_rx_serial` passes through a 2-FF synchroniser (both FFs reset to 1), followed by one more register used for falling-edge detect.
- **Tick generator:**
  - `TICK_DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLING)` (integer truncation, must be ≥ 1).
  - Divider is held cleared in IDLE and starts counting on the edge-detect cycle.
  - Emits a one-cycle tick every `TICK_DIV` clocks.
- **Tick counter:** a `$clog2(OVERSAMPLING)`-bit counter, plus a 3-bit bit index.
- **IDLE:**
  - A synchronised 1→0 transition moves to START.
  - A line held low (break) does not retrigger, because detection is edge-based.
- **START:**
  - After `OVERSAMPLING/2` ticks, sample the line.
  - 0: clear the tick counter and go to DATA.
  - 1: glitch; return to IDLE with no output.
- **DATA:**
  - Every `OVERSAMPLING` ticks, sample and shift into the shift register, LSB first.
  - After the 8th sample, go to STOP.
- **STOP:** after `OVERSAMPLING` ticks, sample the line.
  - 1: load `o_rx_data` from the shift register and pulse `o_rx_valid`.
  - 0: pulse `o_rx_error`; `o_rx_data` is unchanged.
  - Either way, return to IDLE in the same cycle.
- **No backpressure.** A new byte overwrites the previous one unflagged.
- **Reset behaviour:** `i_reset` at any time, including mid-frame, forces IDLE. Reset values:
  - `o_rx_data = 0`, `o_rx_valid = 0`, `o_rx_error = 0`, `o_rx_busy = 0`.
  - Shift register, divider and counters are cleared.
  - Synchroniser FFs are set to 1.
- **Reset release:** a frame already in progress at reset release is only picked up on its next falling edge.

## Timing
- Let E be the first cycle in which the synchronised line reads 0 after reading 1. E is 2 cycles after the pin transition.
- START sample: tick `OVERSAMPLING/2`, at cycle E + (OVERSAMPLING/2)·TICK_DIV.
- Data bit k: sampled at E + (OVERSAMPLING/2 + (k+1)·OVERSAMPLING)·TICK_DIV.
- `o_rx_valid` / `o_rx_error`: asserted exactly in cycle E + (OVERSAMPLING/2 + 9·OVERSAMPLING)·TICK_DIV + 1, for one cycle.
  - Defaults: TICK_DIV = 54, so assertion is at E + 8209.
- `o_rx_busy`: rises in cycle E+1 and falls in the same cycle as the valid/error pulse.
- Back-to-back frames: the next start edge can be detected from the cycle after the pulse. Half a stop bit of margin remains before the next start bit.
- Valid and error are never asserted together.

## Structure
- Package `uart_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, STOP);
  - `DATA_BITS = 8`;
  - the function computing `TICK_DIV` from the three parameters, shared with `UART_TX`.
- Sub-module `uart_baud_tick`: the parameterised divider, with an enable/clear input and a tick output. It is reusable by the transmitter.
- The synchroniser and FSM stay inline in `uart_rx`.

## Test plan
Default parameters apply throughout (TICK_DIV = 54, 864 clocks per bit).
- **Single frame:** drive 8N1 frame 0xA5 → `o_rx_data = 8'hA5`, `o_rx_valid` high for exactly one cycle at E+8209, `o_rx_error` stays 0, `o_rx_busy` high from E+1 to E+8209.
- **Glitch rejection:** pulse the line low for 200 cycles (< 432) → returns to IDLE, no valid, no error; a following 0x3C frame is received correctly.
- **Framing error:** send 0x5A with stop bit 0, then hold the line low for 5 bit times, then release and send 0x81:
  - `o_rx_error` pulses once and `o_rx_data` keeps its previous value;
  - there is no retrigger during the break;
  - 0x81 is then received.
- **Back-to-back with rate error:** frames 0x00, 0xFF, 0x55 with one stop bit each, at bit period 864 and again at 847 (+2% rate) → three valid pulses with the correct bytes in order.
- **Reset mid-frame:** assert `i_reset` for 1 cycle during data bit 3 of 0xC3:
  - all outputs are 0 the next cycle;
  - no pulse is produced for the remainder of that frame;
  - the next frame 0x96 is received correctly.
- **Loopback:** `UART_TX` → `uart_rx` with identical parameters, 256 random bytes → every byte matches in order, zero errors.
